// File: rtl/spi_pkg.sv
// ============================================================================
// Module  : spi_pkg
// Brief   : Shared word length and receiver state type for the SPI link.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

  localparam int SPI_DATA_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_recv_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_recv_if.sv
// ============================================================================
// Module  : spi_recv_if
// Brief   : SPI pins toward the receiver plus its parallel word output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_recv_if
  import spi_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
);

  logic              spi_clk;
  logic              spi_csn;
  logic              spi_sdi;
  logic [DATA_W-1:0] o_data;
  logic              o_data_en;
  logic              o_busy;
  logic              o_frame_err;

  modport master (
    output spi_clk, spi_csn, spi_sdi,
    input  o_data, o_data_en, o_busy, o_frame_err
  );

  modport slave (
    input  spi_clk, spi_csn, spi_sdi,
    output o_data, o_data_en, o_busy, o_frame_err
  );

endinterface

`default_nettype wire

// File: rtl/spi_sync.sv
// ============================================================================
// Module  : spi_sync
// Brief   : Multi-flop synchronizer with selectable reset level.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= {STAGES{RESET_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_recv.sv
// ============================================================================
// Module  : spi_recv
// Brief   : SPI mode-0 slave receiver, oversampled entirely in sys_clk.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_recv
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        sys_reset_n,
  spi_recv_if.slave   bus
);

  localparam int               CNT_W    = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] c_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [2:0]       c_SETTLE = 3'(SYNC_STAGES + 1);

  logic w_sclk_s;
  logic w_csn_s;
  logic w_sdi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_clk (
    .clk(sys_clk), .rst_n(sys_reset_n), .d(bus.spi_clk), .q(w_sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
    .clk(sys_clk), .rst_n(sys_reset_n), .d(bus.spi_csn), .q(w_csn_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk(sys_clk), .rst_n(sys_reset_n), .d(bus.spi_sdi), .q(w_sdi_s)
  );

  logic       r_sclk_d;
  logic       r_csn_d;
  logic       r_clk_rise;
  logic       r_csn_rise;
  logic       r_csn_fall;
  logic       r_sdi;
  logic [2:0] r_settle;
  logic       r_armed;

  logic w_clk_rise;
  logic w_csn_fall;
  logic w_csn_rise;

  assign w_clk_rise = w_sclk_s & ~r_sclk_d;
  assign w_csn_fall = ~w_csn_s & r_csn_d;
  assign w_csn_rise = w_csn_s & ~r_csn_d;

  // Edges are registered together with the matching sdi sample. A frame is
  // only accepted once csn has been seen high after the pipeline refilled
  // from reset, so a transfer already under way at reset release is skipped.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_sclk_d   <= 1'b0;
      r_csn_d    <= 1'b1;
      r_clk_rise <= 1'b0;
      r_csn_rise <= 1'b0;
      r_csn_fall <= 1'b0;
      r_sdi      <= 1'b0;
      r_settle   <= 3'd0;
      r_armed    <= 1'b0;
    end else begin
      r_sclk_d   <= w_sclk_s;
      r_csn_d    <= w_csn_s;
      r_clk_rise <= w_clk_rise;
      r_csn_rise <= w_csn_rise;
      r_csn_fall <= w_csn_fall & r_armed;
      r_sdi      <= w_sdi_s;
      if (r_settle != c_SETTLE) begin
        r_settle <= r_settle + 3'd1;
      end else if (w_csn_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  spi_recv_state_t   r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data;
  logic              r_data_en;
  logic              r_frame_err;

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_data_en   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_data_en   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_csn_fall) begin
            r_state   <= SHIFT;
            r_bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (r_clk_rise) begin
            r_shift <= {r_shift[DATA_W-2:0], r_sdi};
            if (r_bit_cnt == c_LAST) begin
              r_data    <= {r_shift[DATA_W-2:0], r_sdi};
              r_data_en <= 1'b1;
              r_bit_cnt <= '0;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          // A bit arriving with the csn rise counts before the word check.
          if (r_csn_rise) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            if (r_clk_rise) begin
              r_frame_err <= (r_bit_cnt != c_LAST);
            end else begin
              r_frame_err <= (r_bit_cnt != '0);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_data      = r_data;
  assign bus.o_data_en   = r_data_en;
  assign bus.o_busy      = (r_state == SHIFT);
  assign bus.o_frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_recv.sv
// ============================================================================
// Module  : tb_spi_recv
// Brief   : Directed bench for spi_recv (SYNC_STAGES 2 and 3 instances).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_recv;

  localparam int DW = 16;

  logic sys_clk = 1'b0;
  logic sys_reset_n = 1'b0;

  always #10 sys_clk = ~sys_clk;

  spi_recv_if #(.DATA_W(DW)) bus ();
  spi_recv_if #(.DATA_W(DW)) bus3 ();

  assign bus3.spi_clk = bus.spi_clk;
  assign bus3.spi_csn = bus.spi_csn;
  assign bus3.spi_sdi = bus.spi_sdi;

  spi_recv #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .bus(bus)
  );
  spi_recv #(.DATA_W(DW), .SYNC_STAGES(3)) dut3 (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n), .bus(bus3)
  );

  int vectors = 0;
  int miscompares = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  logic [DW-1:0] data_q[$];

  always @(negedge sys_clk) begin
    if (bus.o_data_en === 1'b1) begin
      en_cnt++;
      data_q.push_back(bus.o_data);
    end
    if (bus.o_frame_err === 1'b1) err_cnt++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic spi_bit(input logic b);
    @(negedge sys_clk);
    bus.spi_sdi = b;
    cycles(3);
    bus.spi_clk = 1'b1;
    cycles(4);
    bus.spi_clk = 1'b0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int i = DW - 1; i >= 0; i--) spi_bit(w[i]);
  endtask

  task automatic csn_low();
    @(negedge sys_clk);
    bus.spi_csn = 1'b0;
    cycles(4);
  endtask

  task automatic csn_high();
    @(negedge sys_clk);
    bus.spi_csn = 1'b1;
    cycles(8);
  endtask

  task automatic test_reset();
    cycles(3);
    vectors++;
    if (bus.o_data !== 16'h0000) begin
      miscompares++; $display("FAIL reset_data got %h want 0000", bus.o_data);
    end
    vectors++;
    if (bus.o_data_en !== 1'b0) begin
      miscompares++; $display("FAIL reset_data_en got %b want 0", bus.o_data_en);
    end
    vectors++;
    if (bus.o_busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got %b want 0", bus.o_busy);
    end
    vectors++;
    if (bus.o_frame_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_frame_err got %b want 0", bus.o_frame_err);
    end
    @(negedge sys_clk);
    sys_reset_n = 1'b1;
    cycles(8);
  endtask

  task automatic test_single();
    int e0, r0;
    e0 = en_cnt; r0 = err_cnt; data_q.delete();
    csn_low();
    vectors++;
    if (bus.o_busy !== 1'b1) begin
      miscompares++; $display("FAIL single_busy_hi got %b want 1", bus.o_busy);
    end
    send_word(16'haa11);
    csn_high();
    vectors++;
    if (en_cnt - e0 !== 1) begin
      miscompares++; $display("FAIL single_en_count got %0d want 1", en_cnt - e0);
    end
    vectors++;
    if (bus.o_data !== 16'haa11) begin
      miscompares++; $display("FAIL single_data got %h want aa11", bus.o_data);
    end
    vectors++;
    if (err_cnt - r0 !== 0) begin
      miscompares++; $display("FAIL single_err got %0d want 0", err_cnt - r0);
    end
    vectors++;
    if (bus.o_busy !== 1'b0) begin
      miscompares++; $display("FAIL single_busy_lo got %b want 0", bus.o_busy);
    end
  endtask

  task automatic test_partial();
    int e0, r0;
    e0 = en_cnt; r0 = err_cnt;
    csn_low();
    for (int i = 0; i < 9; i++) spi_bit(i[0]);
    csn_high();
    vectors++;
    if (err_cnt - r0 !== 1) begin
      miscompares++; $display("FAIL partial_err got %0d want 1", err_cnt - r0);
    end
    vectors++;
    if (en_cnt - e0 !== 0) begin
      miscompares++; $display("FAIL partial_en got %0d want 0", en_cnt - e0);
    end
    vectors++;
    if (bus.o_data !== 16'haa11) begin
      miscompares++; $display("FAIL partial_data got %h want aa11", bus.o_data);
    end
  endtask

  task automatic test_back_to_back();
    int e0, r0;
    logic [DW-1:0] first, second;
    e0 = en_cnt; r0 = err_cnt; data_q.delete();
    csn_low();
    send_word(16'h1234);
    send_word(16'hfedc);
    csn_high();
    first  = (data_q.size() >= 1) ? data_q[0] : 'x;
    second = (data_q.size() >= 2) ? data_q[1] : 'x;
    vectors++;
    if (en_cnt - e0 !== 2) begin
      miscompares++; $display("FAIL b2b_en_count got %0d want 2", en_cnt - e0);
    end
    vectors++;
    if (first !== 16'h1234) begin
      miscompares++; $display("FAIL b2b_word0 got %h want 1234", first);
    end
    vectors++;
    if (second !== 16'hfedc) begin
      miscompares++; $display("FAIL b2b_word1 got %h want fedc", second);
    end
    vectors++;
    if (err_cnt - r0 !== 0) begin
      miscompares++; $display("FAIL b2b_err got %0d want 0", err_cnt - r0);
    end
  endtask

  task automatic test_idle_clocks();
    int e0, r0;
    e0 = en_cnt; r0 = err_cnt;
    for (int i = 0; i < 20; i++) spi_bit(1'b1);
    vectors++;
    if (bus.o_busy !== 1'b0) begin
      miscompares++; $display("FAIL idle_busy got %b want 0", bus.o_busy);
    end
    csn_low();
    send_word(16'h0001);
    csn_high();
    vectors++;
    if (en_cnt - e0 !== 1) begin
      miscompares++; $display("FAIL idle_en_count got %0d want 1", en_cnt - e0);
    end
    vectors++;
    if (bus.o_data !== 16'h0001) begin
      miscompares++; $display("FAIL idle_data got %h want 0001", bus.o_data);
    end
    vectors++;
    if (err_cnt - r0 !== 0) begin
      miscompares++; $display("FAIL idle_err got %0d want 0", err_cnt - r0);
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] w;
    int e0, r0;
    w = 16'h3c5a;
    e0 = en_cnt; r0 = err_cnt;
    csn_low();
    for (int i = DW - 1; i >= 1; i--) spi_bit(w[i]);
    @(negedge sys_clk);
    bus.spi_sdi = w[0];
    cycles(3);
    bus.spi_clk = 1'b1;
    bus.spi_csn = 1'b1;
    cycles(4);
    bus.spi_clk = 1'b0;
    cycles(8);
    vectors++;
    if (en_cnt - e0 !== 1) begin
      miscompares++; $display("FAIL simul_en got %0d want 1", en_cnt - e0);
    end
    vectors++;
    if (bus.o_data !== 16'h3c5a) begin
      miscompares++; $display("FAIL simul_data got %h want 3c5a", bus.o_data);
    end
    vectors++;
    if (err_cnt - r0 !== 0) begin
      miscompares++; $display("FAIL simul_err got %0d want 0", err_cnt - r0);
    end
  endtask

  task automatic test_reset_midframe();
    int e0, r0;
    csn_low();
    for (int i = 0; i < 8; i++) spi_bit(1'b1);
    @(negedge sys_clk);
    sys_reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.o_data !== 16'h0000) begin
      miscompares++; $display("FAIL rstmid_data got %h want 0000", bus.o_data);
    end
    vectors++;
    if (bus.o_busy !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_busy got %b want 0", bus.o_busy);
    end
    cycles(2);
    sys_reset_n = 1'b1;
    e0 = en_cnt; r0 = err_cnt;
    for (int i = 0; i < 8; i++) spi_bit(1'b0);
    vectors++;
    if (bus.o_busy !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_ignored_busy got %b want 0", bus.o_busy);
    end
    csn_high();
    csn_low();
    send_word(16'h8001);
    csn_high();
    vectors++;
    if (bus.o_data !== 16'h8001) begin
      miscompares++; $display("FAIL rstmid_new_data got %h want 8001", bus.o_data);
    end
    vectors++;
    if (en_cnt - e0 !== 1) begin
      miscompares++; $display("FAIL rstmid_en got %0d want 1", en_cnt - e0);
    end
    vectors++;
    if (err_cnt - r0 !== 0) begin
      miscompares++; $display("FAIL rstmid_err got %0d want 0", err_cnt - r0);
    end
  endtask

  task automatic test_latency();
    logic [DW-1:0] w;
    int lat2, lat3;
    w = 16'h5a5a;
    lat2 = 0; lat3 = 0;
    csn_low();
    for (int i = DW - 1; i >= 1; i--) spi_bit(w[i]);
    @(negedge sys_clk);
    bus.spi_sdi = w[0];
    cycles(3);
    bus.spi_clk = 1'b1;
    @(posedge sys_clk);
    for (int k = 1; k <= 8; k++) begin
      @(posedge sys_clk);
      #1;
      if (lat2 == 0 && bus.o_data_en === 1'b1) lat2 = k;
      if (lat3 == 0 && bus3.o_data_en === 1'b1) lat3 = k;
    end
    @(negedge sys_clk);
    bus.spi_clk = 1'b0;
    csn_high();
    vectors++;
    if (lat2 !== 3) begin
      miscompares++; $display("FAIL latency_s2 got %0d want 3", lat2);
    end
    vectors++;
    if (lat3 !== 4) begin
      miscompares++; $display("FAIL latency_s3 got %0d want 4", lat3);
    end
    vectors++;
    if (bus3.o_data !== 16'h5a5a) begin
      miscompares++; $display("FAIL latency_s3_data got %h want 5a5a", bus3.o_data);
    end
  endtask

  initial begin
    bus.spi_clk = 1'b0;
    bus.spi_csn = 1'b1;
    bus.spi_sdi = 1'b0;
    test_reset();
    test_single();
    test_partial();
    test_back_to_back();
    test_idle_clocks();
    test_simultaneous();
    test_reset_midframe();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
